cmd_queue_cntrl: RTL and testbench
==================================

# cmd_queue_cntrl

Multi-stop successor to the follower's command controller. Accepts UART commands, queues up to DEPTH destination station IDs, drives the motion `go` while travelling, and retires the head destination when the barcode reader reports a matching station ID. Sits between the UART/barcode receivers and the motion controller/piezo buzzer. ID width, queue depth and buzzer rate are parametrised.

## Interface
- ID_W, 6: station ID width; command width is ID_W+2.
- DEPTH, 4: destination queue depth; power of 2, at least 2.
- BUZZ_DIV, 6250: buzzer half-period in clk cycles.
- DWELL_CYC, 1000: dwell length in cycles; used only when CMD_DWELL_EN is defined.
- clk  in  1  system clock; the block uses one clock.
- rst_n  in  1  reset; synchronous, active-low.
- cmd  in  ID_W+2  command; [ID_W+1:ID_W] is the opcode, [ID_W-1:0] is the destination.
- cmd_rdy  in  1  command valid; held high until cleared.
- ID  in  ID_W  station ID from the barcode reader.
- ID_vld  in  1  ID valid; held high until cleared.
- OK2Move  in  1  path clear.
- clr_cmd_rdy  out  1  one-cycle pulse; consumes the command.
- clr_ID_vld  out  1  one-cycle pulse; consumes the ID.
- in_transit  out  1  high while in TRANSIT.
- go  out  1  in_transit & OK2Move (combinational).
- buzz, buzz_n  out  1  piezo drive pair; buzz_n = ~buzz.
- dest_ID  out  ID_W  head of queue; 0 when the queue is empty.
- q_cnt  out  $clog2(DEPTH)+1  queue occupancy.
- arrived  out  1  one-cycle pulse when the head is retired.
- cmd_err  out  1  one-cycle pulse on a dropped GO or an illegal opcode.

## Operation
- Opcodes:
  - 01 GO: enqueue the destination.
  - 00 STOP: flush the queue and go to IDLE.
  - 11 SKIP: pop the head without an arrival pulse.
  - 10 illegal: no state change; cmd_err pulses.
- Command accept condition: cmd_rdy & ~clr_cmd_rdy. Every accepted command gets exactly one clr_cmd_rdy, including dropped and illegal ones.
- ID accept condition: ID_vld & ~clr_ID_vld. Every accepted ID gets exactly one clr_ID_vld, including non-matching ones.
- States: IDLE, TRANSIT, plus DWELL when CMD_DWELL_EN is defined.
- IDLE:
  - Accepted GO → enqueue, then TRANSIT.
  - Accepted IDs are consumed and ignored.
- TRANSIT:
  - ID == dest_ID → pop the head and pulse arrived. Go to IDLE if the queue is now empty, otherwise stay in TRANSIT.
  - ID != dest_ID → consume only.
  - SKIP that empties the queue → IDLE.
- GO while q_cnt == DEPTH → command dropped, cmd_err pulses, queue unchanged.
- SKIP or STOP on an empty queue → no-op; no cmd_err.
- Simultaneous events in one cycle:
  - GO and a matching ID → pop and push together; q_cnt unchanged. A full queue accepts this GO.
  - STOP and any ID → STOP wins; the ID is consumed with no arrived pulse.
  - SKIP and a matching ID → a single pop; arrived pulses.
- Buzzer:
  - While in_transit & ~OK2Move, a counter toggles buzz every BUZZ_DIV cycles.
  - Otherwise the counter clears and buzz = 0.
- Queue pointers wrap modulo DEPTH. q_cnt saturates at 0 and at DEPTH.

## Timing
- Reset (rst_n low at a clk edge) forces every output low except buzz_n = 1:
  - state IDLE, queue empty, q_cnt = 0, dest_ID = 0;
  - buzz counter cleared.
- Reset mid-transit or mid-dwell takes effect on that edge.
- Latencies, counting the cmd_rdy/ID_vld sample edge as cycle 0:
  - clr_cmd_rdy and clr_ID_vld are high in cycle 1.
  - in_transit, q_cnt, dest_ID and arrived update at cycle 1.
  - go follows in_transit and OK2Move in the same cycle.
- First buzz toggle occurs BUZZ_DIV cycles after in_transit & ~OK2Move becomes true.
- All outputs except go and buzz_n are registered.

## Configuration
- CMD_DWELL_EN defined:
  - A matching arrival that leaves the queue non-empty enters DWELL. in_transit, go and buzz are low during DWELL.
  - After DWELL_CYC cycles the block returns to TRANSIT.
  - STOP during DWELL → IDLE. GO during DWELL enqueues.
  - A SKIP that empties the queue during DWELL → IDLE; any other SKIP pops without ending the dwell.
  - An ID accepted during DWELL is consumed and ignored.
- CMD_DWELL_EN undefined:
  - The DWELL state and its counter are absent.
  - An arrival with stops remaining stays in TRANSIT.

## Test plan
- Reset, then GO 0x1A with ID_W = 6 → clr_cmd_rdy pulse; in_transit = 1 at the next edge; dest_ID = 0x1A; go = 1 when OK2Move = 1.
- Queue GO 0x05, 0x06, 0x07, then ID 0x13 followed by ID 0x05:
  - ID 0x13 → clr_ID_vld only.
  - ID 0x05 → arrived pulses; dest_ID = 0x06; q_cnt = 2.
  - With CMD_DWELL_EN, in_transit is low for 1000 cycles after the 0x05 arrival.
- Five GOs with DEPTH = 4 → fifth gives cmd_err; q_cnt = 4. Then GO and a matching ID in the same cycle → q_cnt stays 4.
- In transit with OK2Move = 0 → buzz toggles every 6250 cycles and buzz_n is its complement. OK2Move = 1 → buzz = 0 next cycle.
- STOP issued together with a matching ID while q_cnt = 3 → q_cnt = 0, IDLE, no arrived pulse; both clr pulses occur.
- rst_n low mid-transit → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/cmd_queue_cntrl.sv
// -----------------------------------------------------------------------------
// cmd_queue_cntrl
//
// Multi-stop command controller for the line follower. UART commands queue up
// to DEPTH destination station IDs. The block drives the motion `go` while
// travelling, and retires the head destination when the barcode reader reports
// a matching station ID.
//
// Build option: define CMD_DWELL_EN to add a DWELL state. An arrival that
// leaves stops in the queue then pauses for DWELL_CYC cycles before travel
// resumes. Without the macro the DWELL state and its timer are not built, and
// an arrival with stops remaining stays in TRANSIT.
//
// Ports
//   clk, rst_n        system clock, synchronous active-low reset
//   cmd, cmd_rdy      UART command {opcode[1:0], dest[ID_W-1:0]} and its valid
//   ID, ID_vld        station ID from the barcode reader and its valid
//   OK2Move           path clear
//   clr_cmd_rdy       one-cycle pulse, consumes the command
//   clr_ID_vld        one-cycle pulse, consumes the ID
//   in_transit        high while travelling
//   go                in_transit & OK2Move
//   buzz, buzz_n      piezo drive pair, active while blocked in transit
//   dest_ID           head of queue, 0 when the queue is empty
//   q_cnt             queue occupancy
//   arrived           one-cycle pulse when the head is retired by a match
//   cmd_err           one-cycle pulse on a dropped GO or an illegal opcode
// -----------------------------------------------------------------------------
// state    | meaning
// ---------+------------------------------------------------------------------
// IDLE     | queue empty, not moving
// TRANSIT  | travelling to dest_ID; go follows OK2Move
// DWELL    | paused at an intermediate stop (CMD_DWELL_EN only)
// -----------------------------------------------------------------------------
module cmd_queue_cntrl #(
    parameter int ID_W      = 6,
    parameter int DEPTH     = 4,
    parameter int BUZZ_DIV  = 6250,
    parameter int DWELL_CYC = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ID_W+1:0]            cmd,
    input  logic                       cmd_rdy,
    input  logic [ID_W-1:0]            ID,
    input  logic                       ID_vld,
    input  logic                       OK2Move,
    output logic                       clr_cmd_rdy,
    output logic                       clr_ID_vld,
    output logic                       in_transit,
    output logic                       go,
    output logic                       buzz,
    output logic                       buzz_n,
    output logic [ID_W-1:0]            dest_ID,
    output logic [$clog2(DEPTH):0]     q_cnt,
    output logic                       arrived,
    output logic                       cmd_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BUZZ_DIV + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_TRANSIT = 2'd1;
`ifdef CMD_DWELL_EN
    localparam logic [1:0] ST_DWELL   = 2'd2;
    localparam int         DW         = $clog2(DWELL_CYC + 1);
`endif

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;
    localparam logic [1:0] OP_ILL  = 2'b10;
    localparam logic [1:0] OP_SKIP = 2'b11;

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] mem_q [DEPTH];
    logic [ID_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0] dest_ID_q, dest_ID_d;
    logic            in_transit_q, in_transit_d;
    logic            clr_cmd_rdy_q, clr_cmd_rdy_d;
    logic            clr_ID_vld_q, clr_ID_vld_d;
    logic            arrived_q, arrived_d;
    logic            cmd_err_q, cmd_err_d;
    logic            buzz_q, buzz_d;
    logic [BW-1:0]   buzz_cnt_q, buzz_cnt_d;
`ifdef CMD_DWELL_EN
    logic [DW-1:0]   dwell_cnt_q, dwell_cnt_d;
`endif

    logic            cmd_acc;
    logic            id_acc;
    logic [1:0]      opcode;
    logic [ID_W-1:0] head;
    logic            is_stop;
    logic            is_go;
    logic            is_skip;
    logic            is_ill;
    logic            id_match;
    logic            pop;
    logic            push;
    logic            full;
    logic            buzz_on;

    always_comb begin
        cmd_acc  = cmd_rdy & ~clr_cmd_rdy_q;
        id_acc   = ID_vld & ~clr_ID_vld_q;
        opcode   = cmd[ID_W+1:ID_W];
        head     = mem_q[rd_ptr_q];
        is_stop  = cmd_acc & (opcode == OP_STOP);
        is_go    = cmd_acc & (opcode == OP_GO);
        is_skip  = cmd_acc & (opcode == OP_SKIP);
        is_ill   = cmd_acc & (opcode == OP_ILL);
        full     = (cnt_q == CW'(DEPTH));

        // IDs only retire the head while travelling; in IDLE/DWELL they are
        // consumed and dropped.
        id_match = id_acc & (state_q == ST_TRANSIT) & (cnt_q != '0) & (ID == head);

        // A SKIP coinciding with a match collapses into the single match pop.
        pop      = id_match | (is_skip & (cnt_q != '0));

        // A full queue still takes a GO when the head leaves in the same cycle.
        push     = is_go & (~full | pop);

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;

        if (is_stop) begin
            rd_ptr_d = wr_ptr_q;
            cnt_d    = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                mem_d[wr_ptr_q] = cmd[ID_W-1:0];
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        clr_cmd_rdy_d = cmd_acc;
        clr_ID_vld_d  = id_acc;
        arrived_d     = id_match & ~is_stop;
        cmd_err_d     = (is_go & ~push) | is_ill;
        dest_ID_d     = (cnt_d == '0) ? '0 : mem_d[rd_ptr_d];
    end

    // Next state
    always_comb begin
        state_d = state_q;
`ifdef CMD_DWELL_EN
        dwell_cnt_d = dwell_cnt_q;
`endif
        if (is_stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (push) begin
                        state_d = ST_TRANSIT;
                    end
                end
                ST_TRANSIT: begin
                    if (cnt_d == '0) begin
                        state_d = ST_IDLE;
`ifdef CMD_DWELL_EN
                    end else if (id_match) begin
                        state_d     = ST_DWELL;
                        dwell_cnt_d = DW'(DWELL_CYC - 1);
`endif
                    end
                end
`ifdef CMD_DWELL_EN
                ST_DWELL: begin
                    if (cnt_d == '0) begin
                        state_d = ST_IDLE;
                    end else if (dwell_cnt_q == '0) begin
                        state_d = ST_TRANSIT;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - DW'(1);
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
        in_transit_d = (state_d == ST_TRANSIT);
    end

    // Buzzer: counter runs only while blocked in transit, so the first toggle
    // lands BUZZ_DIV cycles after the blocking starts.
    always_comb begin
        buzz_on    = in_transit_q & ~OK2Move;
        buzz_cnt_d = '0;
        buzz_d     = 1'b0;
        if (buzz_on) begin
            if (buzz_cnt_q == BW'(BUZZ_DIV - 1)) begin
                buzz_cnt_d = '0;
                buzz_d     = ~buzz_q;
            end else begin
                buzz_cnt_d = buzz_cnt_q + BW'(1);
                buzz_d     = buzz_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            dest_ID_q     <= '0;
            in_transit_q  <= 1'b0;
            clr_cmd_rdy_q <= 1'b0;
            clr_ID_vld_q  <= 1'b0;
            arrived_q     <= 1'b0;
            cmd_err_q     <= 1'b0;
            buzz_q        <= 1'b0;
            buzz_cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef CMD_DWELL_EN
            dwell_cnt_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            dest_ID_q     <= dest_ID_d;
            in_transit_q  <= in_transit_d;
            clr_cmd_rdy_q <= clr_cmd_rdy_d;
            clr_ID_vld_q  <= clr_ID_vld_d;
            arrived_q     <= arrived_d;
            cmd_err_q     <= cmd_err_d;
            buzz_q        <= buzz_d;
            buzz_cnt_q    <= buzz_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
`ifdef CMD_DWELL_EN
            dwell_cnt_q   <= dwell_cnt_d;
`endif
        end
    end

    assign clr_cmd_rdy = clr_cmd_rdy_q;
    assign clr_ID_vld  = clr_ID_vld_q;
    assign in_transit  = in_transit_q;
    assign go          = in_transit_q & OK2Move;
    assign buzz        = buzz_q;
    assign buzz_n      = ~buzz_q;
    assign dest_ID     = dest_ID_q;
    assign q_cnt       = cnt_q;
    assign arrived     = arrived_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_cmd_queue_cntrl.sv
module tb_cmd_queue_cntrl;

    localparam int ID_W      = 6;
    localparam int DEPTH     = 4;
    localparam int BUZZ_DIV  = 6250;
    localparam int DWELL_CYC = 1000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [ID_W+1:0] cmd;
    logic            cmd_rdy;
    logic [ID_W-1:0] ID;
    logic            ID_vld;
    logic            OK2Move;
    logic            clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n;
    logic [ID_W-1:0] dest_ID;
    logic [$clog2(DEPTH):0] q_cnt;
    logic            arrived, cmd_err;

    int errors = 0;
    int checks = 0;

    cmd_queue_cntrl #(
        .ID_W(ID_W), .DEPTH(DEPTH), .BUZZ_DIV(BUZZ_DIV), .DWELL_CYC(DWELL_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .ID(ID),
        .ID_vld(ID_vld), .OK2Move(OK2Move), .clr_cmd_rdy(clr_cmd_rdy),
        .clr_ID_vld(clr_ID_vld), .in_transit(in_transit), .go(go), .buzz(buzz),
        .buzz_n(buzz_n), .dest_ID(dest_ID), .q_cnt(q_cnt), .arrived(arrived),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Reference model: destination list as a queue plus a coarse mode number
    // (0 idle, 1 travelling, 2 dwelling) and pulse flags.
    logic [ID_W-1:0] m_q[$];
    int  m_state = 0;
    int  m_dwell = 0;
    int  m_bcnt  = 0;
    bit  m_clr_cmd = 0, m_clr_id = 0, m_arr = 0, m_err = 0, m_buzz = 0;

    task automatic mdl_update();
        bit cacc, iacc, match, popped, blocked;
        logic [1:0] op;
        if (!rst_n) begin
            m_q.delete();
            m_state = 0; m_dwell = 0; m_bcnt = 0;
            m_clr_cmd = 0; m_clr_id = 0; m_arr = 0; m_err = 0; m_buzz = 0;
            return;
        end
        cacc = cmd_rdy && !m_clr_cmd;
        iacc = ID_vld && !m_clr_id;
        op   = cmd[ID_W+1:ID_W];
        blocked = (m_state == 1) && !OK2Move;
        if (blocked) begin
            m_bcnt++;
            if (m_bcnt == BUZZ_DIV) begin
                m_buzz = !m_buzz;
                m_bcnt = 0;
            end
        end else begin
            m_bcnt = 0;
            m_buzz = 0;
        end
        m_clr_cmd = cacc;
        m_clr_id  = iacc;
        m_arr = 0;
        m_err = 0;
        match = iacc && (m_state == 1) && (m_q.size() > 0) && (ID == m_q[0]);
        if (cacc && op == 2'b00) begin
            m_q.delete();
            m_state = 0;
            return;
        end
        popped = 0;
        if (match) begin
            void'(m_q.pop_front());
            m_arr = 1;
            popped = 1;
        end
        if (cacc) begin
            case (op)
                2'b01: if (m_q.size() < DEPTH) m_q.push_back(cmd[ID_W-1:0]); else m_err = 1;
                2'b11: if (!popped && m_q.size() > 0) void'(m_q.pop_front());
                2'b10: m_err = 1;
                default: ;
            endcase
        end
        if (m_q.size() == 0) begin
            m_state = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
`ifdef CMD_DWELL_EN
            if (match) begin
                m_state = 2;
                m_dwell = DWELL_CYC;
            end
`endif
        end else begin
            m_dwell--;
            if (m_dwell == 0) m_state = 1;
        end
    endtask

    // Advance one clock; inputs are stable at the edge, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        mdl_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cmd_rdy = 1'b0; ID_vld = 1'b0; OK2Move = 1'b1;
        cmd = '0; ID = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [ID_W-1:0] d);
        cmd = {op, d};
        cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
    endtask

    task automatic send_id(input logic [ID_W-1:0] d);
        ID = d;
        ID_vld = 1'b1;
        tick();
        ID_vld = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_transit !== 1'b0) begin errors++; $display("FAIL reset_in_transit got=%b exp=0", in_transit); end
        checks++; if (q_cnt !== '0) begin errors++; $display("FAIL reset_q_cnt got=%0d exp=0", q_cnt); end
        checks++; if (dest_ID !== '0) begin errors++; $display("FAIL reset_dest got=%h exp=0", dest_ID); end
        checks++; if ({buzz, buzz_n} !== 2'b01) begin errors++; $display("FAIL reset_buzz got=%b%b exp=01", buzz, buzz_n); end
    endtask

    task automatic test_single_go();
        do_reset();
        OK2Move = 1'b1;
        send_cmd(2'b01, 6'h1A);
        checks++; if (clr_cmd_rdy !== 1'b1) begin errors++; $display("FAIL go_clr got=%b exp=1", clr_cmd_rdy); end
        checks++; if (in_transit !== 1'b1) begin errors++; $display("FAIL go_in_transit got=%b exp=1", in_transit); end
        checks++; if (dest_ID !== 6'h1A) begin errors++; $display("FAIL go_dest got=%h exp=1a", dest_ID); end
        checks++; if (go !== 1'b1) begin errors++; $display("FAIL go_go got=%b exp=1", go); end
        tick();
        checks++; if (clr_cmd_rdy !== 1'b0) begin errors++; $display("FAIL go_clr_pulse got=%b exp=0", clr_cmd_rdy); end
        OK2Move = 1'b0;
        #1;
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL go_blocked got=%b exp=0", go); end
        OK2Move = 1'b1;
    endtask

    task automatic test_queue_arrival();
        int low;
        do_reset();
        send_cmd(2'b01, 6'h05); tick();
        send_cmd(2'b01, 6'h06); tick();
        send_cmd(2'b01, 6'h07); tick();
        checks++; if (q_cnt !== 3'd3) begin errors++; $display("FAIL q3_cnt got=%0d exp=3", q_cnt); end
        send_id(6'h13);
        checks++; if ({clr_ID_vld, arrived} !== 2'b10) begin errors++; $display("FAIL nomatch got clr/arr=%b%b exp=10", clr_ID_vld, arrived); end
        checks++; if (q_cnt !== 3'd3) begin errors++; $display("FAIL nomatch_cnt got=%0d exp=3", q_cnt); end
        tick();
        send_id(6'h05);
        checks++; if (arrived !== 1'b1) begin errors++; $display("FAIL arrive_pulse got=%b exp=1", arrived); end
        checks++; if (dest_ID !== 6'h06) begin errors++; $display("FAIL arrive_dest got=%h exp=06", dest_ID); end
        checks++; if (q_cnt !== 3'd2) begin errors++; $display("FAIL arrive_cnt got=%0d exp=2", q_cnt); end
`ifdef CMD_DWELL_EN
        low = (in_transit === 1'b0) ? 1 : 0;
        for (int i = 0; i < DWELL_CYC + 50; i++) begin
            if (in_transit === 1'b1 || low == 0) break;
            tick();
            if (in_transit === 1'b0) low++;
        end
        checks++; if (low != DWELL_CYC) begin errors++; $display("FAIL dwell_len got=%0d exp=%0d", low, DWELL_CYC); end
`else
        low = 0;
        checks++; if (in_transit !== 1'b1) begin errors++; $display("FAIL arrive_stay got=%b exp=1 low=%0d", in_transit, low); end
`endif
        tick();
        checks++; if (arrived !== 1'b0) begin errors++; $display("FAIL arrive_one_pulse got=%b exp=0", arrived); end
    endtask

    task automatic test_full_queue();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send_cmd(2'b01, 6'(i));
            tick();
        end
        send_cmd(2'b01, 6'h05);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL full_err got=%b exp=1", cmd_err); end
        checks++; if (q_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt got=%0d exp=4", q_cnt); end
        tick();
        cmd = {2'b01, 6'h2A}; cmd_rdy = 1'b1;
        ID = 6'h01; ID_vld = 1'b1;
        tick();
        cmd_rdy = 1'b0; ID_vld = 1'b0;
        checks++; if (q_cnt !== 3'd4) begin errors++; $display("FAIL pushpop_cnt got=%0d exp=4", q_cnt); end
        checks++; if ({arrived, cmd_err} !== 2'b10) begin errors++; $display("FAIL pushpop_flags got arr/err=%b%b exp=10", arrived, cmd_err); end
        checks++; if (dest_ID !== 6'h02) begin errors++; $display("FAIL pushpop_dest got=%h exp=02", dest_ID); end
        tick();
        send_cmd(2'b10, 6'h09);
        checks++; if ({cmd_err, clr_cmd_rdy} !== 2'b11 || q_cnt !== 3'd4) begin errors++; $display("FAIL illegal got err/clr=%b%b cnt=%0d exp=11 cnt=4", cmd_err, clr_cmd_rdy, q_cnt); end
        tick();
        do_reset();
        send_cmd(2'b11, 6'h00);
        checks++; if ({cmd_err, clr_cmd_rdy, q_cnt} !== {2'b01, 3'd0}) begin errors++; $display("FAIL skip_empty got err/clr=%b%b cnt=%0d exp=01 cnt=0", cmd_err, clr_cmd_rdy, q_cnt); end
        tick();
    endtask

    task automatic test_buzzer();
        do_reset();
        OK2Move = 1'b0;
        send_cmd(2'b01, 6'h11);
        checks++; if ({in_transit, go, buzz} !== 3'b100) begin errors++; $display("FAIL buzz_start got it/go/bz=%b%b%b exp=100", in_transit, go, buzz); end
        for (int i = 0; i < BUZZ_DIV - 1; i++) tick();
        checks++; if (buzz !== 1'b0) begin errors++; $display("FAIL buzz_early got=%b exp=0", buzz); end
        tick();
        checks++; if ({buzz, buzz_n} !== 2'b10) begin errors++; $display("FAIL buzz_first got=%b%b exp=10", buzz, buzz_n); end
        for (int i = 0; i < BUZZ_DIV; i++) tick();
        checks++; if ({buzz, buzz_n} !== 2'b01) begin errors++; $display("FAIL buzz_second got=%b%b exp=01", buzz, buzz_n); end
        for (int i = 0; i < BUZZ_DIV; i++) tick();
        checks++; if (buzz !== 1'b1) begin errors++; $display("FAIL buzz_third got=%b exp=1", buzz); end
        OK2Move = 1'b1;
        tick();
        checks++; if ({buzz, buzz_n, go} !== 3'b011) begin errors++; $display("FAIL buzz_clear got bz/bzn/go=%b%b%b exp=011", buzz, buzz_n, go); end
    endtask

    task automatic test_stop_with_id();
        do_reset();
        send_cmd(2'b01, 6'h0A); tick();
        send_cmd(2'b01, 6'h0B); tick();
        send_cmd(2'b01, 6'h0C); tick();
        checks++; if (q_cnt !== 3'd3) begin errors++; $display("FAIL stop_pre_cnt got=%0d exp=3", q_cnt); end
        cmd = {2'b00, 6'h00}; cmd_rdy = 1'b1;
        ID = 6'h0A; ID_vld = 1'b1;
        tick();
        cmd_rdy = 1'b0; ID_vld = 1'b0;
        checks++; if (q_cnt !== 3'd0 || dest_ID !== '0) begin errors++; $display("FAIL stop_flush got cnt=%0d dest=%h exp=0/0", q_cnt, dest_ID); end
        checks++; if ({in_transit, arrived} !== 2'b00) begin errors++; $display("FAIL stop_state got it/arr=%b%b exp=00", in_transit, arrived); end
        checks++; if ({clr_cmd_rdy, clr_ID_vld} !== 2'b11) begin errors++; $display("FAIL stop_clrs got=%b%b exp=11", clr_cmd_rdy, clr_ID_vld); end
        tick();
    endtask

    task automatic test_reset_mid_transit();
        do_reset();
        OK2Move = 1'b0;
        send_cmd(2'b01, 6'h15);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0; OK2Move = 1'b1; cmd_rdy = 1'b1; cmd = {2'b01, 6'h16};
        tick();
        checks++; if ({clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n, arrived, cmd_err} !== 8'b00000100)
            begin errors++; $display("FAIL midreset_flags got=%b exp=00000100", {clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n, arrived, cmd_err}); end
        checks++; if (q_cnt !== '0 || dest_ID !== '0) begin errors++; $display("FAIL midreset_queue got cnt=%0d dest=%h exp=0/0", q_cnt, dest_ID); end
        cmd_rdy = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [ID_W-1:0] e_dest;
        int r;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst_n = ($urandom % 600 != 0);
            if (!cmd_rdy || m_clr_cmd) begin
                cmd_rdy = ($urandom % 3 == 0);
                r = $urandom % 20;
                cmd[ID_W+1:ID_W] = (r < 11) ? 2'b01 : (r < 15) ? 2'b11 : (r < 17) ? 2'b00 : 2'b10;
                cmd[ID_W-1:0] = 6'($urandom % 8);
            end
            if (!ID_vld || m_clr_id) begin
                ID_vld = ($urandom % 3 == 0);
                if (m_q.size() > 0 && ($urandom % 2 == 1)) ID = m_q[0];
                else ID = 6'($urandom % 8);
            end
            if ($urandom % 40 == 0) OK2Move = ~OK2Move;
            tick();
            e_dest = (m_q.size() > 0) ? m_q[0] : '0;
            checks++; if (clr_cmd_rdy !== m_clr_cmd) begin errors++; $display("FAIL rnd_clr_cmd cyc=%0d got=%b exp=%b", cyc, clr_cmd_rdy, m_clr_cmd); end
            checks++; if (clr_ID_vld !== m_clr_id) begin errors++; $display("FAIL rnd_clr_id cyc=%0d got=%b exp=%b", cyc, clr_ID_vld, m_clr_id); end
            checks++; if (in_transit !== (m_state == 1)) begin errors++; $display("FAIL rnd_in_transit cyc=%0d got=%b exp=%0d", cyc, in_transit, m_state == 1); end
            checks++; if (go !== ((m_state == 1) && OK2Move)) begin errors++; $display("FAIL rnd_go cyc=%0d got=%b", cyc, go); end
            checks++; if (q_cnt !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_q_cnt cyc=%0d got=%0d exp=%0d", cyc, q_cnt, m_q.size()); end
            checks++; if (dest_ID !== e_dest) begin errors++; $display("FAIL rnd_dest cyc=%0d got=%h exp=%h", cyc, dest_ID, e_dest); end
            checks++; if (arrived !== m_arr) begin errors++; $display("FAIL rnd_arrived cyc=%0d got=%b exp=%b", cyc, arrived, m_arr); end
            checks++; if (cmd_err !== m_err) begin errors++; $display("FAIL rnd_cmd_err cyc=%0d got=%b exp=%b", cyc, cmd_err, m_err); end
            checks++; if (buzz !== m_buzz || buzz_n !== ~m_buzz) begin errors++; $display("FAIL rnd_buzz cyc=%0d got=%b%b exp=%b", cyc, buzz, buzz_n, m_buzz); end
        end
        rst_n = 1'b1; cmd_rdy = 1'b0; ID_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd = '0; cmd_rdy = 1'b0; ID = '0; ID_vld = 1'b0; OK2Move = 1'b1;
        test_reset();
        test_single_go();
        test_queue_arrival();
        test_full_queue();
        test_stop_with_id();
        test_reset_mid_transit();
        test_buzzer();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
